// File: rtl/regfile_pkg.sv
// Shared defaults and address-width helper for the regfile_np register file.
package regfile_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_NRD   = 2;

  function automatic int rf_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rf_rdmux.sv
// Single read port: balanced 2:1 mux tree, ra_i LSB selects at the leaf level.
module rf_rdmux import regfile_pkg::*; #(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  localparam int AW   = rf_aw(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs_i,
  input  logic [AW-1:0]               ra_i,
  output logic [WIDTH-1:0]            rd_o
);

  // Level l holds DEPTH>>l candidates; each level halves them using ra_i[l-1].
  for (genvar l = 0; l <= AW; l++) begin : g_lvl
    logic [(DEPTH>>l)-1:0][WIDTH-1:0] v;
    if (l == 0) begin : g_leaf
      assign v = regs_i;
    end else begin : g_tree
      for (genvar j = 0; j < (DEPTH>>l); j++) begin : g_mux
        assign v[j] = ra_i[l-1] ? g_lvl[l-1].v[2*j+1] : g_lvl[l-1].v[2*j];
      end
    end
  end

  assign rd_o = g_lvl[AW].v[0];

endmodule

// File: rtl/regfile_np.sv
// Parameterized register file: one write port, NRD read ports, optional
// hardwired-zero r0, same-cycle write bypass and registered read data.
module regfile_np import regfile_pkg::*; #(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NRD      = RF_NRD,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit RD_REG   = 1'b0,
  localparam int AW      = rf_aw(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      we_i,
  input  logic [AW-1:0]             wa_i,
  input  logic [WIDTH-1:0]          wd_i,
  input  logic [NRD-1:0][AW-1:0]    ra_i,
  output logic [NRD-1:0][WIDTH-1:0] rd_o
);

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d, regs_view;
  logic [NRD-1:0][WIDTH-1:0]   mux_rd;
  logic [NRD-1:0]              hit;
  logic                        wr_ok;

  // Writes to r0 are dropped at the source so bypass and read-register paths agree.
  assign wr_ok = we_i && !(ZERO_REG && (wa_i == '0));

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wa_i] = wd_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) regs_q <= '0;
    else         regs_q <= regs_d;
  end

  always_comb begin
    regs_view = regs_q;
    if (ZERO_REG) regs_view[0] = '0;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_port
    rf_rdmux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mux (
      .regs_i (regs_view),
      .ra_i   (ra_i[i]),
      .rd_o   (mux_rd[i])
    );
    assign hit[i] = wr_ok && (wa_i == ra_i[i]);
  end

  if (RD_REG) begin : g_rdreg
    logic [NRD-1:0][WIDTH-1:0] rd_q, rd_d;

    // Write-first: a read of the address being written captures the new data.
    always_comb begin
      rd_d = '0;
      for (int i = 0; i < NRD; i++) rd_d[i] = hit[i] ? wd_i : mux_rd[i];
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) rd_q <= '0;
      else         rd_q <= rd_d;
    end

    assign rd_o = rd_q;
  end else begin : g_rdcomb
    always_comb begin
      rd_o = '0;
      for (int i = 0; i < NRD; i++) rd_o[i] = (BYPASS && hit[i]) ? wd_i : mux_rd[i];
    end
  end

endmodule

// File: tb/tb_regfile_np.sv
// Directed checks of regfile_np across bypass, zero-register, registered-read
// and a narrow three-port configuration.
module tb_regfile_np;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the three 32x32, 2-port instances.
  logic             reset, we;
  logic [4:0]       wa;
  logic [31:0]      wd;
  logic [1:0][4:0]  ra;
  logic [1:0][31:0] rd_a, rd_b, rd_c;

  // Narrow instance: WIDTH=8, DEPTH=8, NRD=3.
  logic             rst3, we3;
  logic [2:0]       wa3;
  logic [7:0]       wd3;
  logic [2:0][2:0]  ra3;
  logic [2:0][7:0]  rd3;

  int total = 0;
  int bad   = 0;

  // a: defaults (zero reg, bypass, combinational read)
  regfile_np u_a (
    .clk_i(clk), .reset_i(reset), .we_i(we), .wa_i(wa), .wd_i(wd), .ra_i(ra), .rd_o(rd_a)
  );
  // b: no bypass, no zero reg
  regfile_np #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
    .clk_i(clk), .reset_i(reset), .we_i(we), .wa_i(wa), .wd_i(wd), .ra_i(ra), .rd_o(rd_b)
  );
  // c: registered read
  regfile_np #(.RD_REG(1'b1)) u_c (
    .clk_i(clk), .reset_i(reset), .we_i(we), .wa_i(wa), .wd_i(wd), .ra_i(ra), .rd_o(rd_c)
  );
  regfile_np #(.WIDTH(8), .DEPTH(8), .NRD(3)) u_n (
    .clk_i(clk), .reset_i(rst3), .we_i(we3), .wa_i(wa3), .wd_i(wd3), .ra_i(ra3), .rd_o(rd3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
    rst3  = 1'b1; we3 = 1'b0; wa3 = '0; wd3 = '0; ra3 = '0;

    @(negedge clk);
    chk("rdreg_rst0", rd_c[0], 32'h0);
    chk("rdreg_rst1", rd_c[1], 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // every address on both ports reads zero after reset
    for (int a = 0; a < 32; a++) begin
      ra[0] = 5'(a); ra[1] = 5'(31 - a);
      #1;
      chk($sformatf("rst_a%0d_p0", a), rd_a[0], 32'h0);
      chk($sformatf("rst_a%0d_p1", a), rd_a[1], 32'h0);
      chk($sformatf("rst_b%0d_p0", a), rd_b[0], 32'h0);
      @(negedge clk);
    end

    // write r5, read it back on both ports next cycle
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = '0;
    @(negedge clk);
    we = 1'b0; ra[0] = 5'd5; ra[1] = 5'd5;
    #1;
    chk("wr5_a_p0", rd_a[0], 32'hDEADBEEF);
    chk("wr5_a_p1", rd_a[1], 32'hDEADBEEF);
    chk("wr5_b_p0", rd_b[0], 32'hDEADBEEF);
    chk("wr5_c_lat", rd_c[0], 32'h0);
    @(negedge clk);
    chk("wr5_c_p1", rd_c[1], 32'hDEADBEEF);

    // same-cycle write/read of r7
    we = 1'b1; wa = 5'd7; wd = 32'h12345678; ra[0] = 5'd7; ra[1] = 5'd5;
    #1;
    chk("byp_a_p0", rd_a[0], 32'h12345678);
    chk("byp_a_p1", rd_a[1], 32'hDEADBEEF);
    chk("nobyp_b_p0", rd_b[0], 32'h0);
    @(negedge clk);
    chk("wf_c_p0", rd_c[0], 32'h12345678);
    we = 1'b0;
    #1;
    chk("nobyp_b_after", rd_b[0], 32'h12345678);

    // write all-ones to r0
    @(negedge clk);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra = '0;
    #1;
    chk("z_a_byp_p0", rd_a[0], 32'h0);
    chk("z_a_byp_p1", rd_a[1], 32'h0);
    chk("z_b_same", rd_b[0], 32'h0);
    @(negedge clk);
    chk("z_c_p0", rd_c[0], 32'h0);
    we = 1'b0;
    #1;
    chk("z_a_next", rd_a[0], 32'h0);
    chk("z_b_next", rd_b[0], 32'hFFFFFFFF);

    // registered read of r3 appears one cycle later
    @(negedge clk);
    we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5; ra[0] = 5'd3; ra[1] = 5'd3;
    #1;
    chk("rr_c_n", rd_c[0], 32'h0);
    @(negedge clk);
    chk("rr_c_n1_p0", rd_c[0], 32'hA5A5A5A5);
    chk("rr_c_n1_p1", rd_c[1], 32'hA5A5A5A5);

    // both ports on the address being written
    we = 1'b1; wa = 5'd9; wd = 32'h0BADF00D; ra[0] = 5'd9; ra[1] = 5'd9;
    #1;
    chk("mp_a_p0", rd_a[0], 32'h0BADF00D);
    chk("mp_a_p1", rd_a[1], 32'h0BADF00D);
    chk("mp_b_p0", rd_b[0], 32'h0);
    chk("mp_b_p1", rd_b[1], 32'h0);
    @(negedge clk);
    we = 1'b0;
    chk("mp_c_p0", rd_c[0], 32'h0BADF00D);
    chk("mp_c_p1", rd_c[1], 32'h0BADF00D);

    // narrow instance: fill r_k = k+0x10 (r0 stays zero)
    rst3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      we3 = 1'b1; wa3 = 3'(k); wd3 = 8'(k + 8'h10);
      @(negedge clk);
    end
    we3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ra3[0] = 3'(k); ra3[1] = 3'(k + 1); ra3[2] = 3'(k + 2);
      #1;
      chk($sformatf("n_fill_r%0d", k), {24'h0, rd3[0]}, (k == 0) ? 32'h0 : 32'(k + 8'h10));
      chk($sformatf("n_fill_p2_r%0d", (k + 2) % 8), {24'h0, rd3[2]},
          (((k + 2) % 8) == 0) ? 32'h0 : 32'(((k + 2) % 8) + 8'h10));
      @(negedge clk);
    end

    // reset with a concurrent write: reset wins
    rst3 = 1'b1; we3 = 1'b1; wa3 = 3'd2; wd3 = 8'h55;
    @(negedge clk);
    rst3 = 1'b0; we3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ra3[0] = 3'(k); ra3[1] = 3'(7 - k); ra3[2] = 3'(k);
      #1;
      chk($sformatf("n_rst_r%0d_p0", k), {24'h0, rd3[0]}, 32'h0);
      chk($sformatf("n_rst_r%0d_p1", k), {24'h0, rd3[1]}, 32'h0);
      chk($sformatf("n_rst_r%0d_p2", k), {24'h0, rd3[2]}, 32'h0);
      @(negedge clk);
    end

    // first write after reset is accepted
    we3 = 1'b1; wa3 = 3'd4; wd3 = 8'h77; ra3 = '0;
    @(negedge clk);
    we3 = 1'b0; ra3[1] = 3'd4;
    #1;
    chk("n_post_rst_wr", {24'h0, rd3[1]}, 32'h77);
    chk("n_post_rst_r2", {24'h0, rd3[0]}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_np.md
REGFILE_NP -- requirements
Module: regfile_np

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits, >=1.
REQ-002 Parameter DEPTH, default 32: register count; power of two, >=2.
REQ-003 Parameter NRD, default 2: number of independent read ports, 1..4.
REQ-004 Parameter ZERO_REG, default 1: 1 makes register 0 read as all-zeros and ignore writes.
REQ-005 Parameter BYPASS, default 1: 1 makes combinational reads return same-cycle write data on address match.
REQ-006 Parameter RD_REG, default 0: 0 gives combinational read (0-cycle latency); 1 gives registered read (1-cycle latency).
REQ-007 Derived AW = log2(DEPTH); not overridable.
REQ-008 clk  input  1  single clock; all state updates on its rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 we  input  1  write enable.
REQ-011 wa  input  AW  write address.
REQ-012 wd  input  WIDTH  write data.
REQ-013 ra  input  NRD x AW  read address per port.
REQ-014 rd  output  NRD x WIDTH  read data per port.

Function
REQ-015 Write: at rising clk with we=1 and reset=0, reg[wa] <= wd; no other register changes.
REQ-016 ZERO_REG=1: write to wa=0 discarded; any port addressing 0 returns 0, including under bypass.
REQ-017 RD_REG=0: rd[i] = reg[ra[i]] combinationally, valid in the same cycle ra[i] is applied.
REQ-018 RD_REG=0, BYPASS=1: if we=1 and wa==ra[i] (and not the zero register), rd[i] = wd in that cycle.
REQ-019 RD_REG=0, BYPASS=0: on wa==ra[i] with we=1, rd[i] shows the old contents until the edge.
REQ-020 RD_REG=1: rd[i] registered; value at cycle n+1 equals register contents after the write of cycle n (write-first); BYPASS is ignored.
REQ-021 Read ports independent; any ports may share an address and return identical data.
REQ-022 Multiple ports reading wa while we=1 all obey REQ-018/REQ-019/REQ-020 identically.
REQ-023 Read-address decode per port is a balanced 2:1 mux tree of depth AW, LSB of ra selecting at first level.
REQ-024 No X propagation: every legal address reaches a defined register; no out-of-range addresses exist (DEPTH power of two).

Reset
REQ-025 At rising clk with reset=1, all DEPTH registers clear to 0 in that single cycle.
REQ-026 With RD_REG=1, all rd registers clear to 0 on reset; with RD_REG=0, rd reads 0 from the cycle after reset.
REQ-027 reset=1 and we=1 together: reset wins; write discarded.
REQ-028 Reset mid-sequence: writes before the reset edge are lost; first write accepted is the one on the first edge with reset=0.

Structure
REQ-029 Package regfile_pkg holds default constants RF_WIDTH=32, RF_DEPTH=32, RF_NRD=2 and the AW derivation function.
REQ-030 One sub-module rf_rdmux (parameters WIDTH, DEPTH): single read port mux tree; instantiated NRD times via generate.
REQ-031 Storage, write decode, bypass and optional read registers reside in regfile_np.

Verification
REQ-032 Defaults: reset, read all 32 addresses on both ports -> all rd = 0.
REQ-033 Write 0xDEADBEEF to r5, next cycle ra0=5, ra1=5 -> both rd = 0xDEADBEEF.
REQ-034 BYPASS=1, RD_REG=0: we=1, wa=7, wd=0x12345678, ra0=7 same cycle -> rd0=0x12345678 that cycle; BYPASS=0 -> old value (0).
REQ-035 ZERO_REG=1: write 0xFFFFFFFF to r0, bypass active -> rd=0 same and following cycles; ZERO_REG=0 -> 0xFFFFFFFF next cycle.
REQ-036 RD_REG=1: write 0xA5A5A5A5 to r3 with ra0=3 at cycle n -> rd0 = 0xA5A5A5A5 at n+1, not at n.
REQ-037 WIDTH=8, DEPTH=8, NRD=3: fill r_k=k+0x10, assert reset with we=1 wa=2 wd=0x55 -> all reads 0 afterwards.
